// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared pipeline request/control types and run-control states
package pipe_ctrl_pkg;

  localparam int N_STAGE = 4;

  localparam int STG_IF  = 0;
  localparam int STG_ID  = 1;
  localparam int STG_EX  = 2;
  localparam int STG_MEM = 3;

  typedef struct packed {
    logic               stall_req;
    logic [N_STAGE-1:0] flush_req;
  } pipe_req_t;

  typedef struct packed {
    logic stall;
    logic flush;
  } pipe_ctl_t;

  typedef enum logic [1:0] {
    RC_RUN    = 2'd0,
    RC_DRAIN  = 2'd1,
    RC_HALTED = 2'd2,
    RC_STEP   = 2'd3
  } runctl_state_e;

endpackage

// File: rtl/pipe_ctrl_if.sv
// rtl/pipe_ctrl_if.sv - stage request/control, debug and counter bundle
interface pipe_ctrl_if #(
  parameter int CNT_W = 32
);
  import pipe_ctrl_pkg::*;

  pipe_req_t [N_STAGE-1:0] stage_req;
  pipe_ctl_t [N_STAGE-1:0] stage_ctrl;
  logic                    fetch_hold;
  logic                    halt_req;
  logic                    resume_req;
  logic                    step_req;
  logic                    halted;
  logic [CNT_W-1:0]        stall_cnt;
  logic [CNT_W-1:0]        flush_cnt;

  modport master (
    output stage_req, halt_req, resume_req, step_req,
    input  stage_ctrl, fetch_hold, halted, stall_cnt, flush_cnt
  );

  modport slave (
    input  stage_req, halt_req, resume_req, step_req,
    output stage_ctrl, fetch_hold, halted, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/pipe_ctrl_runctl.sv
// rtl/pipe_ctrl_runctl.sv - debug run-control FSM (halt / drain / single-step / resume)
module pipe_runctl
  import pipe_ctrl_pkg::*;
#(
  parameter int DRAIN_CYC = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic halt_req_i,
  input  logic resume_req_i,
  input  logic step_req_i,
  input  logic progress_i,
  input  logic if_moved_i,
  output logic fetch_hold_o,
  output logic flush_if_o,
  output logic halt_all_o,
  output logic halted_o
);

  localparam int CW = (DRAIN_CYC < 1) ? 1 : $clog2(DRAIN_CYC + 1);

  runctl_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= RC_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    fetch_hold_o = 1'b0;
    flush_if_o   = 1'b0;
    halt_all_o   = 1'b0;
    unique case (state_q)
      RC_RUN: begin
        if (halt_req_i) begin
          state_d = RC_DRAIN;
          cnt_d   = CW'(DRAIN_CYC);
        end
      end
      RC_DRAIN: begin
        fetch_hold_o = 1'b1;
        flush_if_o   = 1'b1;
        // Only cycles where the whole pipe advances count toward emptying it
        if (resume_req_i) begin
          state_d = RC_RUN;
        end else if (cnt_q == '0) begin
          state_d = RC_HALTED;
        end else if (progress_i) begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CW'(1)) state_d = RC_HALTED;
        end
      end
      RC_HALTED: begin
        fetch_hold_o = 1'b1;
        halt_all_o   = 1'b1;
        if (resume_req_i)    state_d = RC_RUN;
        else if (step_req_i) state_d = RC_STEP;
      end
      RC_STEP: begin
        if (if_moved_i) begin
          state_d = RC_DRAIN;
          cnt_d   = CW'(DRAIN_CYC);
        end
      end
      default: state_d = RC_RUN;
    endcase
    if (!rst) begin
      fetch_hold_o = 1'b0;
      flush_if_o   = 1'b0;
      halt_all_o   = 1'b0;
    end
  end

  assign halted_o = rst && (state_q == RC_HALTED);

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline sequencer: stall/flush resolution, run control and perf counters
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int NSTAGE    = N_STAGE,
  parameter int CNT_W     = 32,
  parameter int DRAIN_CYC = NSTAGE
) (
  input  logic      clk,
  input  logic      rst,
  pipe_ctrl_if.slave bus
);

  localparam logic [NSTAGE-1:0] ONE = NSTAGE'(1);

  logic [NSTAGE-1:0] sreq, freq_or, stall_v, bubble_v, stall_o, flush_o;
  logic              fetch_hold, flush_if, halt_all, halted;
  logic [CNT_W-1:0]  stall_cnt_q, flush_cnt_q;
  pipe_ctl_t [NSTAGE-1:0] ctrl;

  always_comb begin
    sreq    = '0;
    freq_or = '0;
    for (int i = 0; i < NSTAGE; i++) begin
      sreq[i] = bus.stage_req[i].stall_req;
      freq_or = freq_or | bus.stage_req[i].flush_req;
    end
  end

  // Highest stalling stage wins: everything below it holds, its own output bubbles
  always_comb begin
    stall_v  = '0;
    bubble_v = '0;
    for (int i = 0; i < NSTAGE; i++) begin
      if (sreq[i]) begin
        stall_v  = (ONE << i) - ONE;
        bubble_v = ONE << i;
      end
    end
  end

  pipe_runctl #(.DRAIN_CYC(DRAIN_CYC)) u_runctl (
    .clk          (clk),
    .rst          (rst),
    .halt_req_i   (bus.halt_req),
    .resume_req_i (bus.resume_req),
    .step_req_i   (bus.step_req),
    .progress_i   (stall_v == '0),
    .if_moved_i   (!stall_v[STG_IF]),
    .fetch_hold_o (fetch_hold),
    .flush_if_o   (flush_if),
    .halt_all_o   (halt_all),
    .halted_o     (halted)
  );

  always_comb begin
    stall_o = stall_v;
    flush_o = freq_or | bubble_v;
    if (flush_if) flush_o[STG_IF] = 1'b1;
    if (halt_all) stall_o = '1;
    flush_o = flush_o & ~stall_o;
    if (!rst) begin
      stall_o = '0;
      flush_o = '0;
    end
    for (int i = 0; i < NSTAGE; i++) begin
      ctrl[i].stall = stall_o[i];
      ctrl[i].flush = flush_o[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else if (!halted) begin
      if (|sreq)    stall_cnt_q <= stall_cnt_q + 1'b1;
      if (|freq_or) flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign bus.stage_ctrl = ctrl;
  assign bus.fetch_hold = fetch_hold;
  assign bus.halted     = halted;
  assign bus.stall_cnt  = stall_cnt_q;
  assign bus.flush_cnt  = flush_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - table-driven bench for pipe_ctrl
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;

  pipe_ctrl_if #(.CNT_W(32)) bus();

  pipe_ctrl #(.NSTAGE(4), .CNT_W(32), .DRAIN_CYC(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  sreq;
    logic [15:0] freq;
    logic        halt, resume, step;
    logic [3:0]  e_stall, e_flush;
    logic        e_fh, e_halted;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic add(input string n, input logic [3:0] sreq, input logic [15:0] freq,
                     input logic h, input logic r, input logic s,
                     input logic [3:0] es, input logic [3:0] ef, input logic efh, input logic eh);
    vec_t v;
    v.name = n; v.sreq = sreq; v.freq = freq;
    v.halt = h; v.resume = r; v.step = s;
    v.e_stall = es; v.e_flush = ef; v.e_fh = efh; v.e_halted = eh;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic [3:0] sreq, input logic [15:0] freq,
                       input logic h, input logic r, input logic s);
    for (int j = 0; j < 4; j++) begin
      bus.stage_req[j].stall_req = sreq[j];
      bus.stage_req[j].flush_req = freq[4*j +: 4];
    end
    bus.halt_req   = h;
    bus.resume_req = r;
    bus.step_req   = s;
  endtask

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", n, act, exp);
    end
  endtask

  function automatic logic [3:0] get_stall();
    logic [3:0] r;
    for (int j = 0; j < 4; j++) r[j] = bus.stage_ctrl[j].stall;
    return r;
  endfunction

  function automatic logic [3:0] get_flush();
    logic [3:0] r;
    for (int j = 0; j < 4; j++) r[j] = bus.stage_ctrl[j].flush;
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    drive(4'b0100, 16'h0001, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1; #1;
    chk("rst_stall", 32'(get_stall()), 32'h0);
    chk("rst_flush", 32'(get_flush()), 32'h0);
    chk("rst_fetch_hold", 32'(bus.fetch_hold), 32'h0);
    chk("rst_halted", 32'(bus.halted), 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    drive(4'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("rst_stall_cnt", bus.stall_cnt, 32'd0);
    chk("rst_flush_cnt", bus.flush_cnt, 32'd0);

    for (int i = 0; i < 10; i++) add("idle", 4'b0000, 16'h0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0);
    for (int i = 0; i < 3; i++)  add("ex_stall", 4'b0100, 16'h0, 0, 0, 0, 4'b0011, 4'b0100, 0, 0);
    add("mem_stall_exflush", 4'b1000, 16'h0600, 0, 0, 0, 4'b0111, 4'b1000, 0, 0);
    add("exflush_release",   4'b0000, 16'h0600, 0, 0, 0, 4'b0000, 4'b0110, 0, 0);
    add("halt_pulse",        4'b0000, 16'h0,    1, 0, 0, 4'b0000, 4'b0000, 0, 0);
    add("drain1",            4'b0000, 16'h0,    0, 0, 0, 4'b0000, 4'b0001, 1, 0);
    add("drain_memstall",    4'b1000, 16'h0,    0, 0, 0, 4'b0111, 4'b1000, 1, 0);
    add("drain2",            4'b0000, 16'h0,    0, 0, 0, 4'b0000, 4'b0001, 1, 0);
    add("drain3",            4'b0000, 16'h0,    0, 0, 0, 4'b0000, 4'b0001, 1, 0);
    add("drain4",            4'b0000, 16'h0,    0, 0, 0, 4'b0000, 4'b0001, 1, 0);
    add("halted_ignore_req", 4'b0100, 16'h0,    0, 0, 0, 4'b1111, 4'b0000, 1, 1);
    add("halted_step",       4'b0000, 16'h0,    0, 0, 1, 4'b1111, 4'b0000, 1, 1);
    add("step_if_stalled",   4'b0010, 16'h0,    1, 0, 0, 4'b0001, 4'b0010, 0, 0);
    add("step_go",           4'b0000, 16'h0,    0, 0, 0, 4'b0000, 4'b0000, 0, 0);
    for (int i = 0; i < 4; i++) add("step_drain", 4'b0000, 16'h0, 0, 0, 0, 4'b0000, 4'b0001, 1, 0);
    add("halted_step_resume", 4'b0000, 16'h0,   0, 1, 1, 4'b1111, 4'b0000, 1, 1);
    add("run_after_resume",  4'b0000, 16'h0,    0, 0, 0, 4'b0000, 4'b0000, 0, 0);
    add("halt2",             4'b0000, 16'h0,    1, 0, 0, 4'b0000, 4'b0000, 0, 0);
    add("drain_abort",       4'b0000, 16'h0,    1, 1, 0, 4'b0000, 4'b0001, 1, 0);
    add("run_idle",          4'b0000, 16'h0,    0, 0, 0, 4'b0000, 4'b0000, 0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].sreq, vecs[i].freq, vecs[i].halt, vecs[i].resume, vecs[i].step);
      #1;
      chk($sformatf("%s_%0d_stall", vecs[i].name, i), 32'(get_stall()), 32'(vecs[i].e_stall));
      chk($sformatf("%s_%0d_flush", vecs[i].name, i), 32'(get_flush()), 32'(vecs[i].e_flush));
      chk($sformatf("%s_%0d_fetch_hold", vecs[i].name, i), 32'(bus.fetch_hold), 32'(vecs[i].e_fh));
      chk($sformatf("%s_%0d_halted", vecs[i].name, i), 32'(bus.halted), 32'(vecs[i].e_halted));
      @(posedge clk); #1;
    end
    chk("stall_cnt_total", bus.stall_cnt, 32'd6);
    chk("flush_cnt_total", bus.flush_cnt, 32'd2);

    // Reset in the middle of a drain must drop straight back to RUN
    drive(4'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(4'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("middrain_fetch_hold", 32'(bus.fetch_hold), 32'h1);
    chk("middrain_flush", 32'(get_flush()), 32'h1);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(4'b0100, 16'h0020, 1'b0, 1'b0, 1'b0);
    #1;
    chk("inrst_stall", 32'(get_stall()), 32'h0);
    chk("inrst_flush", 32'(get_flush()), 32'h0);
    chk("inrst_fetch_hold", 32'(bus.fetch_hold), 32'h0);
    chk("inrst_halted", 32'(bus.halted), 32'h0);
    @(posedge clk); #1;
    chk("inrst_stall_cnt", bus.stall_cnt, 32'd0);
    chk("inrst_flush_cnt", bus.flush_cnt, 32'd0);
    rst = 1'b1;
    drive(4'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("postrst_stall", 32'(get_stall()), 32'h0);
    chk("postrst_flush", 32'(get_flush()), 32'h0);
    chk("postrst_fetch_hold", 32'(bus.fetch_hold), 32'h0);
    @(posedge clk); #1;
    chk("postrst2_flush", 32'(get_flush()), 32'h0);
    chk("postrst2_fetch_hold", 32'(bus.fetch_hold), 32'h0);
    chk("postrst2_halted", 32'(bus.halted), 32'h0);
    chk("postrst_stall_cnt", bus.stall_cnt, 32'd0);
    chk("postrst_flush_cnt", bus.flush_cnt, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central pipeline sequencer for the five-stage core. It gathers PipeRequest (stall_req, flush_req) from the IF/ID/EX/MEM stages and produces a PipeControl (stall, flush) for each stage output register. It also runs a debug run-control FSM (halt / drain / single-step / resume) and keeps stall and flush performance counters.

Parameters:
NSTAGE, 4, number of stages with an output register (IF=0, ID=1, EX=2, MEM=3); WB has none.
CNT_W, 32, width of the performance counters.
DRAIN_CYC, NSTAGE, progress cycles needed to empty the pipeline after fetch is frozen.

Ports:
clk  in  1  core clock
rst  in  1  synchronous reset, active-low (0 = reset)
stage_req  in  NSTAGE x PipeRequest  per-stage request; flush_req bit i = bubble stage i output register
stage_ctrl  out  NSTAGE x PipeControl  per-stage stall/flush for stage i output register
fetch_hold  out  1  freezes PC update in the fetch unit
halt_req  in  1  debug halt request (level, sampled each cycle)
resume_req  in  1  debug resume request
step_req  in  1  debug single-step request; honoured only in HALTED
halted  out  1  1 while in HALTED
stall_cnt  out  CNT_W  cycles with any stall_req asserted
flush_cnt  out  CNT_W  cycles with any flush_req bit asserted

Behaviour:
- Stall resolution (combinational, from stage_req and state):
  - k = highest index with stall_req=1.
  - stall[i]=1 for all i<k; flush[k]=1, which bubbles the register after the stalled stage; stages above k run.
  - No stall_req means no stall.
- Flush resolution: flush[i] = OR over all stages of flush_req[i], OR the stall bubble, OR the FSM bubble.
- Priority: stall beats flush. flush[i] is masked to 0 when stall[i]=1. The requester is itself stalled and re-asserts on a later cycle.
- FSM states RUN, DRAIN, HALTED, STEP; reset state is RUN.
  - RUN: halt_req → DRAIN, load drain counter with DRAIN_CYC. resume_req and step_req are ignored.
  - DRAIN: fetch_hold=1 and flush[0] forced to 1 (bubbles into ID). The counter decrements only in cycles where stall[NSTAGE-1:0] are all 0. Counter reaches 0 → HALTED. resume_req → RUN (abort drain).
  - HALTED: stall[i]=1 for all i, fetch_hold=1, halted=1, stage_req ignored. resume_req → RUN. Otherwise step_req → STEP. If resume_req and step_req arrive together, resume wins.
  - STEP: fetch_hold=0 with normal resolution. Stays in STEP until a cycle with stall[0]=0, i.e. one instruction has left IF. It then enters DRAIN with the counter reloaded.
  - halt_req is ignored in DRAIN, HALTED and STEP.
- Counters: stall_cnt and flush_cnt increment by 1 per qualifying cycle, in any state except HALTED. They wrap modulo 2^CNT_W with no saturation.
- Reset: while rst=0, stage_ctrl is all 0, fetch_hold=0, halted=0. On the next edge the state becomes RUN, the drain counter 0, and both counters 0. Reset mid-DRAIN or mid-STEP aborts to RUN with no residual bubble.
- Latency: stage_ctrl and fetch_hold are same-cycle combinational from stage_req and the current state. halted and the counters are registered, with one-cycle latency.

Decomposition:
- The shared package holds PipeRequest and PipeControl, stage index constants (STG_IF..STG_MEM) and the run-control state enum.
- One sub-module, pipe_runctl, contains the FSM, the drain counter, fetch_hold and halted. The top level contains stall/flush resolution and the counters.

Test Plan:
- Idle, all requests 0 for 10 cycles → stage_ctrl all 0, fetch_hold=0, stall_cnt=0, flush_cnt=0.
- EX (2) stall_req=1 for 3 cycles → stall[0..1]=1, flush[2]=1, stall[3]=0 each cycle; stall_cnt=3.
- EX flush_req=4'b0110 while MEM stall_req=1 → stall[0..2]=1, flush[1]=flush[2]=0, flush[3]=1; after MEM releases, flush[1]=flush[2]=1.
- halt_req pulse from RUN, no stalls → DRAIN for 4 cycles with flush[0]=1 and fetch_hold=1, then halted=1 and all stall=1; a MEM stall_req during drain extends DRAIN by one cycle per stalled cycle.
- In HALTED, step_req=1 → one STEP cycle with fetch_hold=0, then 4 DRAIN cycles, then halted=1 again; step_req and resume_req together → RUN.
- rst=0 asserted mid-DRAIN, then released → RUN, stage_ctrl all 0 during reset, counters 0, halted=0.
